// File: rtl/cam_capture_rgb565_pkg.sv
// ----------------------------------------------------------------------------
// cam_capture_rgb565_pkg : shared capture FSM encoding and default geometry
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cam_capture_rgb565_pkg;

  localparam int unsigned DEF_SRC_W  = 640;
  localparam int unsigned DEF_SRC_H  = 480;
  localparam int unsigned DEF_DST_W  = 480;
  localparam int unsigned DEF_DST_H  = 272;
  localparam int unsigned DEF_X_OFF  = 80;
  localparam int unsigned DEF_Y_OFF  = 104;
  localparam int unsigned DEF_ADDR_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  typedef logic [15:0] pixel_t;

endpackage

`default_nettype wire

// File: rtl/cam_capture_rgb565_byte_pair.sv
// ----------------------------------------------------------------------------
// cam_byte_pair : joins high/low camera bytes into one RGB565 pixel strobe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cam_byte_pair
  import cam_capture_rgb565_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] byte_i,
  output logic       pix_vld_o,
  output pixel_t     pix_o
);

  logic       phase_q;
  logic [7:0] hi_q;
  logic       pix_vld_q;
  pixel_t     pix_q;

  // A pending high byte is simply forgotten on clear, so an odd trailing byte never writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q   <= 1'b0;
      hi_q      <= 8'd0;
      pix_vld_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      pix_vld_q <= 1'b0;
      if (clr_i) begin
        phase_q <= 1'b0;
      end else if (en_i) begin
        if (!phase_q) begin
          hi_q    <= byte_i;
          phase_q <= 1'b1;
        end else begin
          pix_q     <= {hi_q, byte_i};
          pix_vld_q <= 1'b1;
          phase_q   <= 1'b0;
        end
      end
    end
  end

  assign pix_vld_o = pix_vld_q;
  assign pix_o     = pix_q;

endmodule

`default_nettype wire

// File: rtl/cam_capture_rgb565.sv
// ----------------------------------------------------------------------------
// cam_capture_rgb565 : camera RGB565 capture of a cropped window into a frame buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cam_capture_rgb565
  import cam_capture_rgb565_pkg::*;
#(
  parameter int unsigned SRC_W  = DEF_SRC_W,
  parameter int unsigned SRC_H  = DEF_SRC_H,
  parameter int unsigned DST_W  = DEF_DST_W,
  parameter int unsigned DST_H  = DEF_DST_H,
  parameter int unsigned X_OFF  = DEF_X_OFF,
  parameter int unsigned Y_OFF  = DEF_Y_OFF,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEnable,
  input  logic              iVsync,
  input  logic              iHref,
  input  logic [7:0]        iData,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [15:0]       oWrData,
  output logic              oFrameDone,
  output logic              oFrameErr
);

  localparam int unsigned       COL_W     = $clog2(SRC_W + 1);
  localparam int unsigned       LINE_W    = $clog2(SRC_H + 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(SRC_W);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(SRC_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DST_W * DST_H - 1);

  logic              vs_q, vs_prev_q, href_q, href_prev_q;
  logic [7:0]        data_q;
  cap_state_e        state_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, done_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  pixel_t            wr_data_q;

  logic        vs_rise, vs_fall, href_fall, capturing, start;
  logic        in_win, wr_hit, last_wr, pix_vld;
  logic [31:0] col_x, line_x;
  pixel_t      pix_data;

  assign vs_rise   = vs_q & ~vs_prev_q;
  assign vs_fall   = ~vs_q & vs_prev_q;
  assign href_fall = ~href_q & href_prev_q;
  assign capturing = (state_q == ST_CAPTURE);
  assign start     = (state_q == ST_WAIT_VS) & vs_fall;

  cam_byte_pair u_byte_pair (
    .clk_i     (iClk),
    .rst_i     (iRst),
    .en_i      (capturing & href_q),
    .clr_i     (href_fall | start),
    .byte_i    (data_q),
    .pix_vld_o (pix_vld),
    .pix_o     (pix_data)
  );

  assign col_x  = 32'(col_q);
  assign line_x = 32'(line_q);
  assign in_win = (col_x >= X_OFF) && (col_x < X_OFF + DST_W) && (col_x < SRC_W) &&
                  (line_x >= Y_OFF) && (line_x < Y_OFF + DST_H);

  // An aborting VSYNC edge suppresses the write so WAIT_VS never sees a strobe.
  assign wr_hit  = capturing & pix_vld & in_win & ~vs_rise;
  assign last_wr = capturing & wr_en_q & (wr_addr_q == LAST_ADDR);

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    addr_d = addr_q;
    if (start) begin
      col_d  = '0;
      line_d = '0;
      addr_d = '0;
    end else if (capturing) begin
      if (href_fall) begin
        col_d = '0;
        if (line_q != LINE_MAX) line_d = line_q + LINE_W'(1);
      end else if (pix_vld && (col_q != COL_MAX)) begin
        col_d = col_q + COL_W'(1);
      end
      if (wr_hit) addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      data_q      <= 8'd0;
      state_q     <= ST_IDLE;
      col_q       <= '0;
      line_q      <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      vs_q        <= iVsync;
      vs_prev_q   <= vs_q;
      href_q      <= iHref;
      href_prev_q <= href_q;
      data_q      <= iData;
      col_q       <= col_d;
      line_q      <= line_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_hit;
      if (wr_hit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= pix_data;
      end
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE:    if (iEnable) state_q <= ST_WAIT_VS;
        ST_WAIT_VS: if (vs_fall) state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (last_wr) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (vs_rise) begin
            state_q <= ST_WAIT_VS;
            err_q   <= 1'b1;
          end
        end
        ST_DONE:    state_q <= iEnable ? ST_WAIT_VS : ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign oWrEn      = wr_en_q;
  assign oWrAddr    = wr_addr_q;
  assign oWrData    = wr_data_q;
  assign oFrameDone = done_q;
  assign oFrameErr  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_capture_rgb565.sv
// ----------------------------------------------------------------------------
// tb_cam_capture_rgb565 : randomized frames against a queue-based capture model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cam_capture_rgb565;

  localparam int SRC_W  = 16;
  localparam int SRC_H  = 12;
  localparam int DST_W  = 6;
  localparam int DST_H  = 4;
  localparam int X_OFF  = 5;
  localparam int Y_OFF  = 3;
  localparam int ADDR_W = 6;
  localparam int TOTAL  = DST_W * DST_H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              vsync = 1'b1;
  logic              href = 1'b0;
  logic [7:0]        data = 8'd0;
  logic              oWrEn, oFrameDone, oFrameErr;
  logic [ADDR_W-1:0] oWrAddr;
  logic [15:0]       oWrData;

  cam_capture_rgb565 #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H),
    .X_OFF(X_OFF), .Y_OFF(Y_OFF), .ADDR_W(ADDR_W)
  ) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iEnable    (en),
    .iVsync     (vsync),
    .iHref      (href),
    .iData      (data),
    .oWrEn      (oWrEn),
    .oWrAddr    (oWrAddr),
    .oWrData    (oWrData),
    .oFrameDone (oFrameDone),
    .oFrameErr  (oFrameErr)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
    int                c;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  int   m_st = 0;       // model: 0 idle, 1 armed, 2 capturing
  int   m_cnt = 0;
  int   exp_done = 0, exp_err = 0, exp_wr = 0;
  int   done_seen = 0, err_seen = 0, wr_seen = 0;
  logic mon_on = 1'b0;
  logic rst_at_edge = 1'b0;
  logic [ADDR_W-1:0] prev_a = '0;
  logic [15:0]       prev_d = '0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_at_edge) begin
        chk("rst_wren", oWrEn, 0);
        chk("rst_addr", oWrAddr, 0);
        chk("rst_data", oWrData, 0);
        chk("rst_done", oFrameDone, 0);
        chk("rst_err", oFrameErr, 0);
      end else begin
        if (oWrEn) begin
          wr_seen++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, no write expected", oWrAddr, oWrData);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", oWrAddr, e.a);
            chk("wr_data", oWrData, e.d);
            chk("wr_cycle", cyc, e.c);
          end
        end else begin
          chk("hold_addr", oWrAddr, prev_a);
          chk("hold_data", oWrData, prev_d);
        end
        if (oFrameDone) done_seen++;
        if (oFrameErr) err_seen++;
      end
      prev_a = oWrAddr;
      prev_d = oWrData;
    end
  end

  // Reference: a pixel is stored iff capturing and inside the window; addresses count up.
  task automatic model_pixel(input int l, input int p, input logic [15:0] d);
    if (m_st == 2 && p >= X_OFF && p < X_OFF + DST_W && p < SRC_W &&
        l >= Y_OFF && l < Y_OFF + DST_H) begin
      exp_q.push_back('{a: ADDR_W'(m_cnt), d: d, c: cyc + 3});
      m_cnt++;
      exp_wr++;
      if (m_cnt == TOTAL) begin
        exp_done++;
        m_st = en ? 1 : 0;
      end
    end
  endtask

  // mode 0 random full lines, 1 random lengths, 2 {line,col} pattern, 3 short odd line at Y_OFF
  task automatic send_frame(input int mode, input int nlines, input int dis_line, input int rst_line);
    logic [15:0] pix;
    int          nb;
    bit          rst_pend;
    rst_pend = 0;
    pix      = '0;
    vsync    = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    if (m_st == 1) begin
      m_st  = 2;
      m_cnt = 0;
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      if (l == dis_line) en = 1'b0;
      case (mode)
        1:       nb = $urandom_range(1, 2 * SRC_W + 3);
        3:       nb = (l == Y_OFF) ? 2 * X_OFF + 1 : 2 * SRC_W;
        default: nb = 2 * SRC_W;
      endcase
      for (int b = 0; b < nb; b++) begin
        @(negedge clk);
        if (rst_pend) begin
          rst      = 1'b0;
          rst_pend = 0;
          exp_wr  -= exp_q.size();
          exp_q.delete();
          m_st     = en ? 1 : 0;
        end
        href = 1'b1;
        if (b % 2 == 0) begin
          if (mode == 2) pix = {8'(l), 8'(b / 2)};
          else if (l == Y_OFF && b / 2 == X_OFF) pix = 16'hABCD;
          else pix = 16'($urandom);
          data = pix[15:8];
        end else begin
          data = pix[7:0];
          model_pixel(l, b / 2, pix);
        end
        if (l == rst_line && b == 9) begin
          rst      = 1'b1;
          rst_pend = 1;
        end
      end
      @(negedge clk);
      href = 1'b0;
      repeat ($urandom_range(2, 5)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    if (m_st == 2) begin
      exp_err++;
      m_st = 1;
    end
    repeat (6) @(negedge clk);
    chk("frame_pending", exp_q.size(), 0);
    chk("done_count", done_seen, exp_done);
    chk("err_count", err_seen, exp_err);
    chk("write_count", wr_seen, exp_wr);
  endtask

  task automatic arm();
    en = 1'b1;
    if (m_st == 0) m_st = 1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_wren", oWrEn, 0);

    arm();
    send_frame(2, SRC_H, -1, -1);          // pattern frame, completes
    send_frame(0, SRC_H, -1, -1);          // random data, 0xABCD at origin
    send_frame(0, Y_OFF + 2, -1, -1);      // VSYNC early -> error
    send_frame(0, SRC_H, -1, -1);          // restarts at address 0
    send_frame(3, SRC_H, -1, -1);          // dangling odd byte on first window line
    for (int i = 0; i < 4; i++) send_frame(1, SRC_H, -1, -1);
    send_frame(0, SRC_H, Y_OFF + 1, -1);   // enable drops mid-frame, still completes
    send_frame(0, SRC_H, -1, -1);          // idle: no writes
    arm();
    send_frame(0, SRC_H, -1, Y_OFF + 1);   // reset mid-line, frame dropped
    send_frame(2, SRC_H, -1, -1);          // recovers on next VSYNC fall

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
